t07_wire_cut_checker: RTL
=========================

Name: t07_wire_cut_checker

Overview:
- Consumer end of the wire puzzle. Snapshots wire_num and wire_color_bus from the wire generator on game start, then scans the wires one per cycle to find which wire must be cut.
- Judges the player's cut events and reports solved, strike or failed to the game controller and display.
- Sits between the wire generator, the input/debounce front end and the top-level game FSM.

Parameters:
MAX_STRIKES, 3, number of wrong cuts that moves the block to FAILED (range 1..3)

Ports:
clk  in  1  system clock
nrst  in  1  reset, asynchronous, active-low
start  in  1  one-cycle pulse; snapshot the puzzle and begin evaluation; issued after the generator's colour bus is stable
wire_num  in  3  number of wires present; legal 3..6
wire_color_bus  in  18  wire i colour at bits [3i+2:3i], i=0..5
cut_valid  in  1  one-cycle cut strobe from the input front end
cut_idx  in  3  index of the wire being cut
ready  out  1  high while in ARMED (cuts are accepted)
solved  out  1  level; high in SOLVED
failed  out  1  level; high in FAILED
fault  out  1  level; high in FAULT (illegal wire_num)
strike  out  1  one-cycle pulse on each wrong cut
strike_cnt  out  2  wrong cuts so far, saturating
cut_mask  out  6  bit i set once wire i has been cut
target_idx  out  3  computed wire to cut (debug/display); valid from ARMED onward

Behaviour:
- Reset: state IDLE. All outputs, snapshots, counters and cut_mask are 0.
- Colour codes: 0 RED, 1 BLUE, 2 YELLOW, 3 WHITE, 4 BLACK; codes 5..7 are treated as BLACK.
- States: IDLE, SCAN, DECIDE, ARMED, SOLVED, FAILED, FAULT.
- start in any state:
  - Snapshot num and colours.
  - Clear cut_mask, strike_cnt and target_idx.
  - Reset the scan counter and per-colour counts.
  - Go to SCAN if num is 3..6; otherwise go to FAULT.
- SCAN:
  - Processes one wire per cycle, index 0..num-1. Accumulates red/blue/yellow/white/black counts (3-bit each), the last red index, the last blue index and the last wire's colour.
  - After index num-1, go to DECIDE.
- DECIDE: one cycle; computes target_idx by the rule table below, then goes to ARMED.
- Latency: start sampled at edge k gives ready=1 after edge k+num+1.
- Rules, first match wins:
  - 3 wires:
    - red==0 -> 1
    - last colour WHITE -> 2
    - blue>1 -> last blue
    - else 2
  - 4 wires:
    - red>1 -> last red
    - last colour YELLOW and red==0 -> 0
    - blue==1 -> 0
    - yellow>1 -> 3
    - else 1
  - 5 wires:
    - last colour BLACK -> 3
    - red==1 and yellow>1 -> 0
    - black==0 -> 1
    - else 0
  - 6 wires:
    - yellow==0 -> 2
    - yellow==1 and white>1 -> 3
    - red==0 -> 5
    - else 3
- ARMED, on cut_valid:
  - cut_idx >= num -> ignored.
  - cut_mask[cut_idx] already set -> ignored; no strike.
  - cut_idx == target_idx -> set the mask bit; go to SOLVED.
  - Any other cut -> set the mask bit; pulse strike for one cycle; strike_cnt += 1. If the new count equals MAX_STRIKES, go to FAILED.
- cut_valid outside ARMED: ignored.
- SOLVED, FAILED and FAULT are terminal until the next start or reset.
- A start pulse during SCAN aborts the current evaluation and restarts from the new snapshot.
- Input changes after the snapshot have no effect until the next start.
- start and cut_valid in the same cycle: start wins and the cut is dropped.
- Reset mid-operation: immediate return to the reset state.

Decomposition:
- Package t07_wire_pkg holds:
  - colour enum (3-bit)
  - checker state enum
  - MAX_WIRES=6, MIN_WIRES=3 constants
- One sub-module, t07_wire_rule_scan, holds the scan counter and the colour/last-index accumulators. It takes a clear pulse and an enable, and outputs a done flag plus the counts.
- The top level holds the FSM, the DECIDE rule table, cut_mask and the strike logic.

Test Plan:
- num=3, bus=18'h000C9 (BLUE, BLUE, WHITE), start -> ready=1 after 4 cycles, target_idx=1. Cut 1 -> solved=1, strike never pulses, cut_mask=6'b000010.
- num=4, bus=18'h00440 (RED, RED, BLUE, YELLOW) -> target_idx=1.
  - Cut 0 -> strike pulse, strike_cnt=1.
  - Cut 0 again -> no strike, strike_cnt stays 1.
  - Cut 6 -> ignored.
  - Cut 1 -> solved=1, cut_mask=6'b000011.
- num=6, bus=0 (all RED) -> target_idx=2. Cuts 0, 1, 3 -> three strike pulses, then failed=1 and ready=0. A further cut has no effect.
- num=2, start -> fault=1, ready=0. New start with num=5, last wire BLACK -> fault=0, target_idx=3.
- start at SCAN cycle 2 with a different bus -> the result reflects only the second snapshot. start and cut_valid in the same cycle -> no strike.
- Assert nrst low while ARMED with strike_cnt=2 -> all outputs 0 immediately, state IDLE.

Source files
------------

// File: rtl/t07_wire_pkg.sv
// t07_wire_pkg: shared colour/state types and wire-count limits for the wire puzzle checker
package t07_wire_pkg;
   typedef enum logic [2:0] {
      C_RED    = 3'd0,
      C_BLUE   = 3'd1,
      C_YELLOW = 3'd2,
      C_WHITE  = 3'd3,
      C_BLACK  = 3'd4
   } color_e;
   typedef enum logic [2:0] {
      S_IDLE,
      S_SCAN,
      S_DECIDE,
      S_ARMED,
      S_SOLVED,
      S_FAILED,
      S_FAULT
   } state_e;
   localparam int MAX_WIRES = 6;
   localparam int MIN_WIRES = 3;
   // Codes 5..7 are not real colours; the puzzle treats them as black.
   function automatic color_e to_color(input logic [2:0] c);
      return (c > 3'd4) ? C_BLACK : color_e'(c);
   endfunction
endpackage

// File: rtl/t07_wire_rule_scan.sv
// t07_wire_rule_scan: walks the snapshotted wires one per cycle, accumulating colour statistics
//   clk, nrst        clock, async active-low reset
//   clr              restart the scan (index and all accumulators to 0)
//   en               process wire at the current index this cycle
//   num, colors      snapshotted wire count and colour bus
//   done             current index is the last wire
//   *_cnt            per-colour counts of processed wires
//   last_red/blue    index of the most recent red/blue wire
//   last_color       colour of the most recently processed wire
module t07_wire_rule_scan
   import t07_wire_pkg::*;
(
   input  logic                     clk,
   input  logic                     nrst,
   input  logic                     clr,
   input  logic                     en,
   input  logic [2:0]               num,
   input  logic [3*MAX_WIRES-1:0]   colors,
   output logic                     done,
   output logic [2:0]               red_cnt,
   output logic [2:0]               blue_cnt,
   output logic [2:0]               yellow_cnt,
   output logic [2:0]               white_cnt,
   output logic [2:0]               black_cnt,
   output logic [2:0]               last_red,
   output logic [2:0]               last_blue,
   output color_e                   last_color
);
   logic [2:0] idx_q, idx_d, red_q, red_d, blue_q, blue_d, yellow_q, yellow_d;
   logic [2:0] white_q, white_d, black_q, black_d, lred_q, lred_d, lblue_q, lblue_d;
   color_e     last_q, last_d, col;

   always_comb begin
      col = C_RED;
      for (int i = 0; i < MAX_WIRES; i++)
         if (idx_q == 3'(i)) col = to_color(colors[3*i +: 3]);
      idx_d    = idx_q;
      red_d    = red_q;
      blue_d   = blue_q;
      yellow_d = yellow_q;
      white_d  = white_q;
      black_d  = black_q;
      lred_d   = lred_q;
      lblue_d  = lblue_q;
      last_d   = last_q;
      if (clr) begin
         idx_d    = '0;
         red_d    = '0;
         blue_d   = '0;
         yellow_d = '0;
         white_d  = '0;
         black_d  = '0;
         lred_d   = '0;
         lblue_d  = '0;
         last_d   = C_RED;
      end else if (en) begin
         idx_d    = idx_q + 3'd1;
         red_d    = red_q + 3'(col == C_RED);
         blue_d   = blue_q + 3'(col == C_BLUE);
         yellow_d = yellow_q + 3'(col == C_YELLOW);
         white_d  = white_q + 3'(col == C_WHITE);
         black_d  = black_q + 3'(col == C_BLACK);
         lred_d   = (col == C_RED) ? idx_q : lred_q;
         lblue_d  = (col == C_BLUE) ? idx_q : lblue_q;
         last_d   = col;
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         idx_q    <= '0;
         red_q    <= '0;
         blue_q   <= '0;
         yellow_q <= '0;
         white_q  <= '0;
         black_q  <= '0;
         lred_q   <= '0;
         lblue_q  <= '0;
         last_q   <= C_RED;
      end else begin
         idx_q    <= idx_d;
         red_q    <= red_d;
         blue_q   <= blue_d;
         yellow_q <= yellow_d;
         white_q  <= white_d;
         black_q  <= black_d;
         lred_q   <= lred_d;
         lblue_q  <= lblue_d;
         last_q   <= last_d;
      end
   end

   assign done       = (idx_q == num - 3'd1);
   assign red_cnt    = red_q;
   assign blue_cnt   = blue_q;
   assign yellow_cnt = yellow_q;
   assign white_cnt  = white_q;
   assign black_cnt  = black_q;
   assign last_red   = lred_q;
   assign last_blue  = lblue_q;
   assign last_color = last_q;
endmodule

// File: rtl/t07_wire_cut_checker.sv
// t07_wire_cut_checker: snapshots the wire puzzle, derives the wire to cut and judges player cuts
//   clk, nrst              clock, async active-low reset
//   start                  snapshot wire_num/wire_color_bus and restart evaluation
//   wire_num               wire count (legal 3..6)
//   wire_color_bus         3-bit colour per wire, wire i at [3i+2:3i]
//   cut_valid, cut_idx     cut strobe and the wire being cut
//   ready                  cuts accepted (ARMED)
//   solved/failed/fault    terminal status levels
//   strike, strike_cnt     wrong-cut pulse and saturating wrong-cut count
//   cut_mask               wires cut so far
//   target_idx             computed wire to cut
module t07_wire_cut_checker
   import t07_wire_pkg::*;
#(
   parameter int MAX_STRIKES = 3
)(
   input  logic                     clk,
   input  logic                     nrst,
   input  logic                     start,
   input  logic [2:0]               wire_num,
   input  logic [3*MAX_WIRES-1:0]   wire_color_bus,
   input  logic                     cut_valid,
   input  logic [2:0]               cut_idx,
   output logic                     ready,
   output logic                     solved,
   output logic                     failed,
   output logic                     fault,
   output logic                     strike,
   output logic [1:0]               strike_cnt,
   output logic [MAX_WIRES-1:0]     cut_mask,
   output logic [2:0]               target_idx
);
   state_e                   state_q, state_d;
   logic [2:0]               num_q, num_d, target_q, target_d, rule_tgt;
   logic [3*MAX_WIRES-1:0]   bus_q, bus_d;
   logic [MAX_WIRES-1:0]     mask_q, mask_d, cut_bit;
   logic [1:0]               cnt_q, cnt_d, cnt_inc;
   logic                     strike_q, strike_d, scan_done, cut_ok;
   logic [2:0]               red, blue, yellow, white, black, lred, lblue;
   color_e                   last;

   t07_wire_rule_scan u_scan (
      .clk        (clk),
      .nrst       (nrst),
      .clr        (start),
      .en         (state_q == S_SCAN && !start),
      .num        (num_q),
      .colors     (bus_q),
      .done       (scan_done),
      .red_cnt    (red),
      .blue_cnt   (blue),
      .yellow_cnt (yellow),
      .white_cnt  (white),
      .black_cnt  (black),
      .last_red   (lred),
      .last_blue  (lblue),
      .last_color (last)
   );

   // Rule table, first match wins; only 3..6 ever reach DECIDE, so default is the 6-wire case.
   always_comb begin
      case (num_q)
         3'd3:    rule_tgt = (red == 3'd0) ? 3'd1 : (last == C_WHITE) ? 3'd2 :
                             (blue > 3'd1) ? lblue : 3'd2;
         3'd4:    rule_tgt = (red > 3'd1) ? lred : (last == C_YELLOW && red == 3'd0) ? 3'd0 :
                             (blue == 3'd1) ? 3'd0 : (yellow > 3'd1) ? 3'd3 : 3'd1;
         3'd5:    rule_tgt = (last == C_BLACK) ? 3'd3 : (red == 3'd1 && yellow > 3'd1) ? 3'd0 :
                             (black == 3'd0) ? 3'd1 : 3'd0;
         default: rule_tgt = (yellow == 3'd0) ? 3'd2 : (yellow == 3'd1 && white > 3'd1) ? 3'd3 :
                             (red == 3'd0) ? 3'd5 : 3'd3;
      endcase
   end

   always_comb begin
      cut_bit  = 6'b1 << cut_idx;
      cut_ok   = cut_valid && (cut_idx < num_q) && !(|(mask_q & cut_bit));
      cnt_inc  = (cnt_q == 2'd3) ? cnt_q : cnt_q + 2'd1;
      state_d  = state_q;
      num_d    = num_q;
      bus_d    = bus_q;
      target_d = target_q;
      mask_d   = mask_q;
      cnt_d    = cnt_q;
      strike_d = 1'b0;
      // start overrides everything, including a cut in the same cycle.
      if (start) begin
         num_d    = wire_num;
         bus_d    = wire_color_bus;
         target_d = '0;
         mask_d   = '0;
         cnt_d    = '0;
         state_d  = (wire_num >= 3'(MIN_WIRES) && wire_num <= 3'(MAX_WIRES)) ? S_SCAN : S_FAULT;
      end else begin
         case (state_q)
            S_SCAN:   state_d = scan_done ? S_DECIDE : S_SCAN;
            S_DECIDE: begin
               target_d = rule_tgt;
               state_d  = S_ARMED;
            end
            S_ARMED:  if (cut_ok) begin
               mask_d = mask_q | cut_bit;
               if (cut_idx == target_q) state_d = S_SOLVED;
               else begin
                  strike_d = 1'b1;
                  cnt_d    = cnt_inc;
                  state_d  = (int'(cnt_inc) == MAX_STRIKES) ? S_FAILED : S_ARMED;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q  <= S_IDLE;
         num_q    <= '0;
         bus_q    <= '0;
         target_q <= '0;
         mask_q   <= '0;
         cnt_q    <= '0;
         strike_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         num_q    <= num_d;
         bus_q    <= bus_d;
         target_q <= target_d;
         mask_q   <= mask_d;
         cnt_q    <= cnt_d;
         strike_q <= strike_d;
      end
   end

   assign ready      = (state_q == S_ARMED);
   assign solved     = (state_q == S_SOLVED);
   assign failed     = (state_q == S_FAILED);
   assign fault      = (state_q == S_FAULT);
   assign strike     = strike_q;
   assign strike_cnt = cnt_q;
   assign cut_mask   = mask_q;
   assign target_idx = target_q;
endmodule
